// File: rtl/dsp_mac_seq.sv
// dsp_mac_seq: sequencer that drives a DSP slice through a signed
// multiply-accumulate job. It clears the M/P registers, feeds len operand
// pairs through a valid/ready handshake, and waits for the DSP pipeline
// to drain. It then captures P as the job result.
module dsp_mac_seq #(
  parameter int LEN_W = 8,
  parameter int M_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [17:0]      in_a,
  input  logic [17:0]      in_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ceopmode,
  output logic             dsp_cea,
  output logic             dsp_ceb,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_rstm,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic [47:0]      result,
  output logic             result_valid,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    FEED  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] count;
  logic [M_LAT:0]   en_pipe;
  logic             hs;

  // Operands go straight to the DSP A/B ports.
  // The A1/B1 enables fire only on a real transfer.
  assign in_ready     = (state == FEED) && (count < len_q);
  assign hs           = in_valid && in_ready;
  assign dsp_a        = in_a;
  assign dsp_b        = in_b;
  assign dsp_cea      = hs;
  assign dsp_ceb      = hs;
  assign dsp_cem      = en_pipe[M_LAT-1];
  assign dsp_cep      = en_pipe[M_LAT];
  assign dsp_rstm     = (state == CLEAR);
  assign dsp_rstp     = (state == CLEAR);
  assign dsp_opmode   = 8'h09;
  assign dsp_ceopmode = 1'b1;
  assign busy         = (state != IDLE);

  // Enable pipeline: each handshake walks down to the M enable and then to the P enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_pipe <= '0;
    end else begin
      en_pipe <= {en_pipe[M_LAT-1:0], hs};
    end
  end

  // Job sequencer: accepts start, counts transfers, waits for the pipeline to drain, and captures P.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      len_q        <= '0;
      count        <= '0;
      result       <= 48'h0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            count <= '0;
            if (len != '0) begin
              state <= CLEAR;
            end else begin
              state        <= DONE;
              result       <= 48'h0;
              result_valid <= 1'b1;
            end
          end
        end
        CLEAR: begin
          count <= '0;
          state <= FEED;
        end
        FEED: begin
          if (hs) begin
            count <= count + 1'b1;
            if (count == len_q - 1'b1) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (en_pipe == '0) begin
            state        <= DONE;
            result       <= dsp_p;
            result_valid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb_dsp_mac_seq: drives dsp_mac_seq against a behavioural DSP slice.
// Table vectors cover the named scenarios and random jobs are checked
// against a sum-of-products reference model.
module tb_dsp_mac_seq;

  localparam int LEN_W = 8;
  localparam int M_LAT = 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [17:0]      in_a = '0;
  logic [17:0]      in_b = '0;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ceopmode, dsp_cea, dsp_ceb, dsp_cem, dsp_cep;
  logic             dsp_rstm, dsp_rstp;
  logic [47:0]      dsp_p;
  logic [47:0]      result;
  logic             result_valid, busy;

  int errors = 0;
  int checks = 0;

  dsp_mac_seq #(.LEN_W(LEN_W), .M_LAT(M_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode),
    .dsp_ceopmode(dsp_ceopmode), .dsp_cea(dsp_cea), .dsp_ceb(dsp_ceb),
    .dsp_cem(dsp_cem), .dsp_cep(dsp_cep), .dsp_rstm(dsp_rstm),
    .dsp_rstp(dsp_rstp), .dsp_p(dsp_p), .result(result),
    .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural DSP slice: A1/B1 -> M -> P, with opmode 09 meaning P + M.
  logic [17:0]        a1 = '0;
  logic [17:0]        b1 = '0;
  logic [47:0]        m_reg = '0;
  logic [47:0]        p_reg = '0;
  logic signed [35:0] prod;
  assign prod  = $signed(a1) * $signed(b1);
  assign dsp_p = p_reg;

  always @(posedge clk) begin
    if (dsp_cea) a1 <= dsp_a;
    if (dsp_ceb) b1 <= dsp_b;
    if (dsp_rstm) m_reg <= '0;
    else if (dsp_cem) m_reg <= {{12{prod[35]}}, prod};
    if (dsp_rstp) p_reg <= '0;
    else if (dsp_cep) p_reg <= (dsp_opmode == 8'h09) ? p_reg + m_reg : p_reg;
  end

  // Cycle counter and cumulative per-cycle activity counters, sampled mid-cycle.
  int cyc = 0;
  int cnt_cea = 0, cnt_cem = 0, cnt_cep = 0, cnt_rstp = 0, cnt_rstm = 0, cnt_rv = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    cnt_cea  <= cnt_cea  + int'(dsp_cea);
    cnt_cem  <= cnt_cem  + int'(dsp_cem);
    cnt_cep  <= cnt_cep  + int'(dsp_cep);
    cnt_rstp <= cnt_rstp + int'(dsp_rstp);
    cnt_rstm <= cnt_rstm + int'(dsp_rstm);
    cnt_rv   <= cnt_rv   + int'(result_valid);
  end

  // Safety net so the bench cannot hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [17:0] job_a [0:255];
  logic [17:0] job_b [0:255];

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0]       gap;
    logic             poke;
    logic [3:0][17:0] a;
    logic [3:0][17:0] b;
    logic [47:0]      exp;
  } vec_t;

  vec_t vecs [7];

  // Reference model: signed sum of products, reduced modulo 2^48.
  function automatic logic [47:0] ref_sum(input int n);
    longint acc;
    longint x;
    longint y;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      x = longint'($signed(job_a[i]));
      y = longint'($signed(job_b[i]));
      acc = acc + x * y;
    end
    return acc[47:0];
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Runs one job from IDLE: start, feed n pairs with gap idle cycles between them, then check the outcome.
  task automatic applyStimulus(input int n, input int gap, input bit poke, input logic [47:0] exp, input string name);
    int c_cea, c_cem, c_cep, c_rstp, c_rstm;
    int hs_cyc;
    int t0;
    bit ok;
    c_cea = cnt_cea; c_cem = cnt_cem; c_cep = cnt_cep;
    c_rstp = cnt_rstp; c_rstm = cnt_rstm;
    start = 1'b1;
    len   = n[LEN_W-1:0];
    t0    = cyc;
    hs_cyc = t0;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    if (n != 0) begin
      checkOutput({name, "_clear_pulse"}, 48'({dsp_rstp, dsp_rstm}), 48'd3);
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          for (int g = 0; g < gap; g++) begin
            if (poke) begin
              start = 1'b1;
              len   = 8'd1;
            end
            @(negedge clk);
            start = 1'b0;
            len   = '0;
          end
        end
        in_valid = 1'b1;
        in_a = job_a[i];
        in_b = job_b[i];
        ok = 1'b0;
        for (int w = 0; w < 20; w++) begin
          if (in_ready) begin
            ok = 1'b1;
            break;
          end
          @(negedge clk);
        end
        if (!ok) begin
          checkOutput({name, "_ready_timeout"}, 48'd0, 48'd1);
          in_valid = 1'b0;
          return;
        end
        hs_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    ok = 1'b0;
    for (int w = 0; w < 600; w++) begin
      if (result_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checkOutput({name, "_result_timeout"}, 48'd0, 48'd1);
      return;
    end
    checkOutput({name, "_result"}, result, exp);
    checkOutput({name, "_latency"}, 48'(cyc - hs_cyc), (n != 0) ? 48'(M_LAT + 3) : 48'd1);
    @(negedge clk);
    checkOutput({name, "_valid_width"}, 48'(result_valid), 48'd0);
    checkOutput({name, "_busy_after"}, 48'(busy), 48'd0);
    checkOutput({name, "_result_hold"}, result, exp);
    checkOutput({name, "_cea_count"}, 48'(cnt_cea - c_cea), 48'(n));
    checkOutput({name, "_cem_count"}, 48'(cnt_cem - c_cem), 48'(n));
    checkOutput({name, "_cep_count"}, 48'(cnt_cep - c_cep), 48'(n));
    checkOutput({name, "_rstp_count"}, 48'(cnt_rstp - c_rstp), (n != 0) ? 48'd1 : 48'd0);
    checkOutput({name, "_rstm_count"}, 48'(cnt_rstm - c_rstm), (n != 0) ? 48'd1 : 48'd0);
  endtask

  // Main sequence: reset state, table vectors, idle/reset corner cases, random jobs.
  initial begin
    int c_cea, c_rv;
    int n;
    int gap;
    logic [47:0] held;
    bit ok;

    vecs[0] = '{len: 8'd3, gap: 4'd0, poke: 1'b0,
                a: {18'd0, 18'h3FFFF, 18'd4, 18'd2}, b: {18'd0, 18'd7, 18'd5, 18'd3}, exp: 48'd19};
    vecs[1] = '{len: 8'd2, gap: 4'd3, poke: 1'b1,
                a: {18'd0, 18'd0, 18'd1, 18'd10}, b: {18'd0, 18'd0, 18'd1, 18'd10}, exp: 48'd101};
    vecs[2] = '{len: 8'd0, gap: 4'd0, poke: 1'b0,
                a: {18'd0, 18'd0, 18'd0, 18'd0}, b: {18'd0, 18'd0, 18'd0, 18'd0}, exp: 48'd0};
    vecs[3] = '{len: 8'd2, gap: 4'd0, poke: 1'b0,
                a: {18'd0, 18'd0, 18'd5, 18'd1000}, b: {18'd0, 18'd0, 18'd5, 18'd1000}, exp: 48'd1000025};
    vecs[4] = '{len: 8'd1, gap: 4'd0, poke: 1'b0,
                a: {18'd0, 18'd0, 18'd0, 18'h1FFFF}, b: {18'd0, 18'd0, 18'd0, 18'h1FFFF}, exp: 48'd17179607041};
    vecs[5] = '{len: 8'd1, gap: 4'd0, poke: 1'b0,
                a: {18'd0, 18'd0, 18'd0, 18'h20000}, b: {18'd0, 18'd0, 18'd0, 18'h1FFFF}, exp: 48'd281457796972544};
    vecs[6] = '{len: 8'd4, gap: 4'd1, poke: 1'b0,
                a: {18'h3FFFD, 18'h3FFFE, 18'd100, 18'd7}, b: {18'd20, 18'h3FFFE, 18'd100, 18'h3FFF7}, exp: 48'd9881};

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 48'(busy), 48'd0);
    checkOutput("reset_in_ready", 48'(in_ready), 48'd0);
    checkOutput("reset_result", result, 48'd0);
    checkOutput("reset_result_valid", 48'(result_valid), 48'd0);
    checkOutput("reset_enables", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp}), 48'd0);
    checkOutput("reset_ceopmode", 48'(dsp_ceopmode), 48'd1);
    checkOutput("opmode", 48'(dsp_opmode), 48'h09);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) begin
        job_a[i] = vecs[v].a[i];
        job_b[i] = vecs[v].b[i];
      end
      applyStimulus(int'(vecs[v].len), int'(vecs[v].gap), vecs[v].poke, vecs[v].exp,
                    $sformatf("vec%0d", v));
    end

    // in_valid while IDLE must not enable anything or disturb the held result.
    held = result;
    c_cea = cnt_cea;
    c_rv  = cnt_rv;
    in_valid = 1'b1;
    in_a = 18'd7;
    in_b = 18'd7;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_valid_cea", 48'(cnt_cea - c_cea), 48'd0);
    checkOutput("idle_valid_rv", 48'(cnt_rv - c_rv), 48'd0);
    checkOutput("idle_valid_busy", 48'(busy), 48'd0);
    checkOutput("idle_valid_result", result, held);

    // Reset in the middle of a job after one of four pairs has been accepted.
    start = 1'b1;
    len   = 8'd4;
    @(negedge clk);
    start = 1'b0;
    len   = '0;
    in_valid = 1'b1;
    in_a = 18'd5;
    in_b = 18'd5;
    ok = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("midreset_ready_seen", 48'(ok), 48'd1);
    @(negedge clk);
    in_a = 18'd6;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_busy", 48'(busy), 48'd0);
    checkOutput("midreset_in_ready", 48'(in_ready), 48'd0);
    checkOutput("midreset_result", result, 48'd0);
    checkOutput("midreset_result_valid", 48'(result_valid), 48'd0);
    checkOutput("midreset_enables", 48'({dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_rstm, dsp_rstp}), 48'd0);
    checkOutput("midreset_ceopmode", 48'(dsp_ceopmode), 48'd1);
    in_valid = 1'b0;
    c_rv = cnt_rv;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("midreset_no_rv", 48'(cnt_rv - c_rv), 48'd0);
    checkOutput("midreset_idle", 48'(busy), 48'd0);
    job_a[0] = 18'd3;
    job_b[0] = 18'd3;
    applyStimulus(1, 0, 1'b0, 48'd9, "after_reset");

    // Random jobs checked against the reference model, ending with the longest legal job.
    for (int r = 0; r < 7; r++) begin
      n   = (r == 6) ? 255 : int'($urandom_range(1, 8));
      gap = (r == 6) ? 0 : int'($urandom_range(0, 2));
      for (int i = 0; i < n; i++) begin
        job_a[i] = 18'($urandom);
        job_b[i] = 18'($urandom);
      end
      applyStimulus(n, gap, r[0], ref_sum(n), $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
